// File: rtl/dx_pipe_stage.sv
// Decode->execute pipeline register with valid/ready handshake, internal operand
// forwarding on load, and re-forwarding into held operands while execute stalls.
module dx_pipe_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned CTRL_W  = 16,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [OP_W-1:0]             in_op,
  input  logic [PC_W-1:0]             in_pc,
  input  logic [PC_W-1:0]             in_pc_jmp,
  input  logic [NUM_SRC*ADDR_W-1:0]   in_src_a,
  input  logic [NUM_SRC*DATA_W-1:0]   in_src_d,
  input  logic [ADDR_W-1:0]           in_dst_a,
  input  logic [DATA_W-1:0]           in_imm,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [OP_W-1:0]             out_op,
  output logic [PC_W-1:0]             out_pc,
  output logic [PC_W-1:0]             out_pc_jmp,
  output logic [NUM_SRC*ADDR_W-1:0]   out_src_a,
  output logic [NUM_SRC*DATA_W-1:0]   out_src_d,
  output logic [ADDR_W-1:0]           out_dst_a,
  output logic [DATA_W-1:0]           out_imm,
  output logic [NUM_SRC-1:0]          fwd_hit
);

  logic                      valid_q,  valid_d;
  logic [CTRL_W-1:0]         ctrl_q,   ctrl_d;
  logic [OP_W-1:0]           op_q,     op_d;
  logic [PC_W-1:0]           pc_q,     pc_d;
  logic [PC_W-1:0]           pc_jmp_q, pc_jmp_d;
  logic [NUM_SRC*ADDR_W-1:0] src_a_q,  src_a_d;
  logic [NUM_SRC*DATA_W-1:0] src_d_q,  src_d_d;
  logic [ADDR_W-1:0]         dst_a_q,  dst_a_d;
  logic [DATA_W-1:0]         imm_q,    imm_d;
  logic [NUM_SRC-1:0]        hit_q,    hit_d;

  logic                      load;
  logic [NUM_SRC*ADDR_W-1:0] sel_a;
  logic [NUM_SRC*DATA_W-1:0] sel_d;
  logic [NUM_SRC*DATA_W-1:0] fwd_d;
  logic [NUM_SRC-1:0]        fwd_m;

  assign in_ready = out_ready | ~valid_q;
  assign load     = in_valid & in_ready;

  // One compare network serves both load (incoming operands) and hold (held operands).
  always_comb begin
    sel_a = load ? in_src_a : src_a_q;
    sel_d = load ? in_src_d : src_d_q;
    fwd_d = sel_d;
    fwd_m = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned j = 0; j < NUM_FWD; j++) begin
        if (!fwd_m[i] && fwd_valid[j] &&
            (fwd_addr[j*ADDR_W +: ADDR_W] == sel_a[i*ADDR_W +: ADDR_W]) &&
            (sel_a[i*ADDR_W +: ADDR_W] != '0)) begin
          fwd_m[i]                   = 1'b1;
          fwd_d[i*DATA_W +: DATA_W]  = fwd_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    op_d     = op_q;
    pc_d     = pc_q;
    pc_jmp_d = pc_jmp_q;
    src_a_d  = src_a_q;
    src_d_d  = src_d_q;
    dst_a_d  = dst_a_q;
    imm_d    = imm_q;
    hit_d    = hit_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      dst_a_d = '0;
      hit_d   = '0;
    end else if (load) begin
      valid_d  = 1'b1;
      ctrl_d   = in_ctrl;
      op_d     = in_op;
      pc_d     = in_pc;
      pc_jmp_d = in_pc_jmp;
      src_a_d  = in_src_a;
      src_d_d  = fwd_d;
      dst_a_d  = in_dst_a;
      imm_d    = in_imm;
      hit_d    = fwd_m;
    end else if (in_ready) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      dst_a_d = '0;
      hit_d   = '0;
    end else begin
      src_d_d = fwd_d;
      hit_d   = fwd_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      op_q     <= '0;
      pc_q     <= '0;
      pc_jmp_q <= '0;
      src_a_q  <= '0;
      src_d_q  <= '0;
      dst_a_q  <= '0;
      imm_q    <= '0;
      hit_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      op_q     <= op_d;
      pc_q     <= pc_d;
      pc_jmp_q <= pc_jmp_d;
      src_a_q  <= src_a_d;
      src_d_q  <= src_d_d;
      dst_a_q  <= dst_a_d;
      imm_q    <= imm_d;
      hit_q    <= hit_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign out_op     = op_q;
  assign out_pc     = pc_q;
  assign out_pc_jmp = pc_jmp_q;
  assign out_src_a  = src_a_q;
  assign out_src_d  = src_d_q;
  assign out_dst_a  = dst_a_q;
  assign out_imm    = imm_q;
  assign fwd_hit    = hit_q;

endmodule

// File: tb/tb_dx_pipe_stage.sv
// Scoreboard bench for dx_pipe_stage: directed loads, forwarding, hold repair,
// bubbles, flushes and asynchronous reset.
module tb_dx_pipe_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned NUM_FWD = 2;

  typedef struct packed {
    logic [CTRL_W-1:0]         ctrl;
    logic [OP_W-1:0]           op;
    logic [PC_W-1:0]           pc;
    logic [PC_W-1:0]           pc_jmp;
    logic [NUM_SRC*ADDR_W-1:0] src_a;
    logic [NUM_SRC*DATA_W-1:0] src_d;
    logic [ADDR_W-1:0]         dst_a;
    logic [DATA_W-1:0]         imm;
    logic [NUM_SRC-1:0]        hit;
  } fld_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [OP_W-1:0]           in_op;
  logic [PC_W-1:0]           in_pc;
  logic [PC_W-1:0]           in_pc_jmp;
  logic [NUM_SRC*ADDR_W-1:0] in_src_a;
  logic [NUM_SRC*DATA_W-1:0] in_src_d;
  logic [ADDR_W-1:0]         in_dst_a;
  logic [DATA_W-1:0]         in_imm;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [OP_W-1:0]           out_op;
  logic [PC_W-1:0]           out_pc;
  logic [PC_W-1:0]           out_pc_jmp;
  logic [NUM_SRC*ADDR_W-1:0] out_src_a;
  logic [NUM_SRC*DATA_W-1:0] out_src_d;
  logic [ADDR_W-1:0]         out_dst_a;
  logic [DATA_W-1:0]         out_imm;
  logic [NUM_SRC-1:0]        fwd_hit;

  int   checks = 0;
  int   errors = 0;
  fld_t sb[$];
  fld_t repaired;

  dx_pipe_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .OP_W(OP_W),
    .CTRL_W(CTRL_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_op(in_op), .in_pc(in_pc), .in_pc_jmp(in_pc_jmp),
    .in_src_a(in_src_a), .in_src_d(in_src_d), .in_dst_a(in_dst_a), .in_imm(in_imm),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_op(out_op), .out_pc(out_pc), .out_pc_jmp(out_pc_jmp),
    .out_src_a(out_src_a), .out_src_d(out_src_d), .out_dst_a(out_dst_a),
    .out_imm(out_imm), .fwd_hit(fwd_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic fld_t act_fields();
    fld_t f;
    f.ctrl = out_ctrl;   f.op = out_op;       f.pc = out_pc;   f.pc_jmp = out_pc_jmp;
    f.src_a = out_src_a; f.src_d = out_src_d; f.dst_a = out_dst_a;
    f.imm = out_imm;     f.hit = fwd_hit;
    return f;
  endfunction

  // Expected output for the instruction currently on the inputs.
  function automatic fld_t exp_now(input logic [NUM_SRC*DATA_W-1:0] srcd,
                                   input logic [NUM_SRC-1:0] hit);
    fld_t f;
    f.ctrl = in_ctrl;   f.op = in_op;  f.pc = in_pc;  f.pc_jmp = in_pc_jmp;
    f.src_a = in_src_a; f.src_d = srcd; f.dst_a = in_dst_a;
    f.imm = in_imm;     f.hit = hit;
    return f;
  endfunction

  task automatic set_in(input logic [7:0] tag, input logic [NUM_SRC*ADDR_W-1:0] srca,
                        input logic [NUM_SRC*DATA_W-1:0] srcd);
    in_valid  = 1'b1;
    in_ctrl   = {8'hC0, tag};
    in_op     = tag[3:0];
    in_pc     = 32'h1000 + {22'd0, tag, 2'b00};
    in_pc_jmp = 32'h8000 + {24'd0, tag};
    in_src_a  = srca;
    in_src_d  = srcd;
    in_dst_a  = tag[4:0] | 5'd1;
    in_imm    = {24'hF00000, tag};
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", act_fields());
      end else begin
        chk("scoreboard", act_fields(), sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_op = '0; in_pc = '0; in_pc_jmp = '0; in_src_a = '0;
    in_src_d = '0; in_dst_a = '0; in_imm = '0;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, act_fields()}, '0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // youngest producer wins when both match
    out_ready = 1'b1;
    set_in(8'd1, {5'd3, 5'd5}, {32'h11, 32'h22});
    fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
    sb.push_back(exp_now({32'h11, 32'hAAAA}, 2'b01));
    @(posedge clk); #1;

    // register 0 never forwarded
    set_in(8'd2, {5'd9, 5'd0}, {32'h5555, 32'hDEAD});
    fwd_valid = 2'b01; fwd_addr = {5'd9, 5'd0}; fwd_data = {32'h7777, 32'h1234};
    sb.push_back(exp_now({32'h5555, 32'hDEAD}, 2'b00));
    @(posedge clk); #1;

    // each operand from a different producer
    set_in(8'd3, {5'd6, 5'd4}, {32'h1, 32'h2});
    fwd_valid = 2'b11; fwd_addr = {5'd6, 5'd4}; fwd_data = {32'h66, 32'h44};
    sb.push_back(exp_now({32'h66, 32'h44}, 2'b11));
    @(posedge clk); #1;

    // bubble
    in_valid = 1'b0; fwd_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("bubble", {out_valid, out_ctrl, out_dst_a, fwd_hit}, '0);

    // load then stall; producer 1 retires src1 during the stall
    set_in(8'd4, {5'd7, 5'd2}, {32'h10, 32'h20});
    out_ready = 1'b0;
    repaired = exp_now({32'h99, 32'h20}, 2'b10);
    @(posedge clk); #1;
    set_in(8'd5, {5'd1, 5'd1}, {32'h0, 32'h0});
    fwd_valid = 2'b10; fwd_addr = {5'd7, 5'd2}; fwd_data = {32'h99, 32'h55};
    @(negedge clk);
    chk("hold_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("hold_repair", {out_valid, act_fields()}, {1'b1, repaired});
    fwd_valid = '0; in_valid = 1'b0; out_ready = 1'b1;
    sb.push_back(repaired);
    @(posedge clk); #1;

    // flush drops a same-cycle input transfer
    set_in(8'd6, {5'd2, 5'd2}, {32'h3, 32'h4});
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_drop", out_valid, 0);
    flush = 1'b0;
    set_in(8'd7, {5'd1, 5'd8}, {32'hAB, 32'hCD});
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd8}; fwd_data = {32'h0, 32'h88};
    sb.push_back(exp_now({32'hAB, 32'h88}, 2'b01));
    @(posedge clk); #1;
    in_valid = 1'b0; fwd_valid = '0;
    @(posedge clk); #1;

    // flush kills a stalled instruction
    set_in(8'd8, {5'd3, 5'd3}, {32'h5, 32'h6});
    fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'h31, 32'h30};
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1; fwd_valid = '0;
    @(posedge clk); #1;
    chk("flush_hold", {out_valid, out_ctrl, out_dst_a, fwd_hit}, '0);
    flush = 1'b0;

    // asynchronous reset while stalled
    set_in(8'd9, {5'd4, 5'd5}, {32'h7, 32'h8});
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("async_reset", {out_valid, act_fields()}, '0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {in_ready, out_valid}, 2'b10);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
